// File: rtl/nand_seq_pkg.sv
// Shared definitions for the bit-serial NAND sequencer.
// Op encodings, controller states and per-op micro-step counts.
package nand_seq_pkg;

    localparam logic [1:0] OP_NAND = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_OR   = 2'd2;
    localparam logic [1:0] OP_XOR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [2:0] steps_per_op(input logic [1:0] op);
        logic [2:0] n;
        case (op)
            OP_NAND: n = 3'd1;
            OP_AND:  n = 3'd2;
            OP_OR:   n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nand_serial_sequencer_snand.sv
// Single 1-bit NAND evaluator shared by every micro-step of the sequencer.
// Kept as its own cell so the controller never grows a second gate.
module nand_serial_sequencer_snand (
    input  logic x,
    input  logic y,
    output logic z
);

    assign z = ~(x & y);

endmodule

// File: rtl/nand_serial_sequencer.sv
// Bit-serial NAND/AND/OR/XOR unit: one NAND evaluation per clock, LSB first.
// Define NAND_STAT_EN to add the saturating nand_count evaluation counter.
module nand_serial_sequencer
    import nand_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef NAND_STAT_EN
    ,
    output logic [15:0]      nand_count
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state;
    state_t state_next;

    logic [1:0]       op_hold;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] b_hold;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_next;
    logic [IW-1:0]    i;
    logic [1:0]       s;
    logic             t;
    logic             u;
    logic             v;

    logic a_bit;
    logic b_bit;
    logic x;
    logic y;
    logic z;
    logic is_final;
    logic last_bit;

    assign a_bit    = a_hold[i];
    assign b_bit    = b_hold[i];
    assign is_final = ({1'b0, s} == steps_per_op(op_hold) - 3'd1);
    assign last_bit = (i == IW'(WIDTH - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // Operand routing into the shared gate for each (op, step) pair.
    always_comb begin
        x = a_bit;
        y = b_bit;
        case (op_hold)
            OP_AND: begin
                if (s == 2'd1) begin
                    x = t;
                    y = t;
                end
            end
            OP_OR: begin
                case (s)
                    2'd0:    begin x = a_bit; y = a_bit; end
                    2'd1:    begin x = b_bit; y = b_bit; end
                    default: begin x = t;     y = u;     end
                endcase
            end
            OP_XOR: begin
                case (s)
                    2'd0:    begin x = a_bit; y = b_bit; end
                    2'd1:    begin x = a_bit; y = t;     end
                    2'd2:    begin x = b_bit; y = t;     end
                    default: begin x = u;     y = v;     end
                endcase
            end
            default: ;
        endcase
    end

    nand_serial_sequencer_snand u_snand (
        .x (x),
        .y (y),
        .z (z)
    );

    always_comb begin
        shadow_next    = shadow;
        shadow_next[i] = z;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        if (is_final && last_bit) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_hold <= '0;
            a_hold  <= '0;
            b_hold  <= '0;
            shadow  <= '0;
            result  <= '0;
            i       <= '0;
            s       <= '0;
            t       <= 1'b0;
            u       <= 1'b0;
            v       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_hold <= op;
                        a_hold  <= a;
                        b_hold  <= b;
                        shadow  <= '0;
                        i       <= '0;
                        s       <= '0;
                    end
                end
                RUN: begin
                    if (!is_final) begin
                        // Non-final steps fill scratch regs in order t, u, v.
                        case (s)
                            2'd0:    t <= z;
                            2'd1:    u <= z;
                            default: v <= z;
                        endcase
                        s <= s + 2'd1;
                    end else begin
                        shadow <= shadow_next;
                        s      <= '0;
                        if (last_bit) result <= shadow_next;
                        else          i      <= i + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NAND_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nand_count <= '0;
        else if (state == RUN && nand_count != 16'hFFFF)
            nand_count <= nand_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_nand_serial_sequencer.sv
// Directed bench for nand_serial_sequencer (WIDTH=16).
// Counter scenario runs only when NAND_STAT_EN is defined.
module tb_nand_serial_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
`ifdef NAND_STAT_EN
    logic [15:0] nand_count;
`endif

    int checks;
    int failures;

    nand_serial_sequencer #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef NAND_STAT_EN
        ,
        .nand_count (nand_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_op(input logic [1:0] o,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
        case (o)
            2'd0:    return ~(x & y);
            2'd1:    return x & y;
            2'd2:    return x | y;
            default: return x ^ y;
        endcase
    endfunction

    // Starts one op, returns edges from acceptance to done and busy-high samples.
    task automatic run_op(input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, output int n,
                          output int nbusy);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        nbusy = busy ? 1 : 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (busy) nbusy++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL timeout op=%0d got no done after %0d cycles", o, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b want=0", done);
        end
        checks++;
        if (result !== 16'h0000) begin
            failures++; $display("FAIL reset_result got=%h want=0000", result);
        end
    endtask

    task automatic test_nand;
        int n, nb;
        run_op(2'd0, 16'hF0F0, 16'hFF00, n, nb);
        checks++;
        if (n !== 16) begin
            failures++; $display("FAIL nand_latency got=%0d want=16", n);
        end
        checks++;
        if (result !== 16'h0FFF) begin
            failures++; $display("FAIL nand_result got=%h want=0fff", result);
        end
        checks++;
        if (nb !== 16) begin
            failures++; $display("FAIL nand_busy_cycles got=%0d want=16", nb);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL nand_busy_in_done got=%b want=0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== 16'h0FFF) begin
            failures++;
            $display("FAIL done_one_cycle done=%b result=%h want 0/0fff",
                     done, result);
        end
    endtask

    task automatic test_xor;
        int n, nb;
        logic [1:0]  o;
        logic [15:0] x, y, want;
        int          lat;
        run_op(2'd3, 16'h1234, 16'h00FF, n, nb);
        checks++;
        if (n !== 64) begin
            failures++; $display("FAIL xor_latency got=%0d want=64", n);
        end
        checks++;
        if (result !== 16'h12CB) begin
            failures++; $display("FAIL xor_result got=%h want=12cb", result);
        end
        for (int k = 0; k < 8; k++) begin
            o = 2'(k % 4);
            x = 16'($urandom);
            y = 16'($urandom);
            want = ref_op(o, x, y);
            lat = 16 * (int'(o) + 1);
            run_op(o, x, y, n, nb);
            checks++;
            if (result !== want || n !== lat) begin
                failures++;
                $display("FAIL rand_op%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                         o, x, y, result, n, want, lat);
            end
        end
    endtask

    task automatic test_or_ignore;
        int n, pulses;
        op = 2'd2; a = 16'h0000; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        op = 2'd3; a = 16'hFFFF; b = 16'h1234;
        n = 0;
        pulses = 0;
        while (n < 400) begin
            if (n >= 40) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        checks++;
        if (n !== 48) begin
            failures++; $display("FAIL or_latency got=%0d want=48", n);
        end
        checks++;
        if (result !== 16'h0000) begin
            failures++; $display("FAIL or_result got=%h want=0000", result);
        end
        if (done) pulses++;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL or_single_done pulses=%0d busy=%b want 1/0",
                     pulses, busy);
        end
    endtask

    task automatic test_back_to_back;
        int n, nb;
        op = 2'd1; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        checks++;
        if (n !== 32 || result !== 16'hFFFF) begin
            failures++;
            $display("FAIL b2b_first got=%0d/%h want=32/ffff", n, result);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy, done);
        end
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        checks++;
        if (n !== 32 || result !== 16'hFFFF) begin
            failures++;
            $display("FAIL b2b_second got=%0d/%h want=32/ffff", n, result);
        end
    endtask

    task automatic test_abort;
        int n, nb;
        op = 2'd3; a = 16'h1234; b = 16'h00FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL abort_async busy=%b done=%b result=%h want 0/0/0000",
                     busy, done, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL abort_idle busy=%b done=%b result=%h want 0/0/0000",
                     busy, done, result);
        end
        run_op(2'd0, 16'hFFFF, 16'h0F0F, n, nb);
        checks++;
        if (n !== 16 || result !== 16'hF0F0) begin
            failures++;
            $display("FAIL abort_recover got=%0d/%h want=16/f0f0", n, result);
        end
    endtask

`ifdef NAND_STAT_EN
    task automatic test_stat;
        int n, nb;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (nand_count !== 16'd0) begin
            failures++; $display("FAIL stat_reset got=%0d want=0", nand_count);
        end
        run_op(2'd1, 16'h1234, 16'h5678, n, nb);
        run_op(2'd3, 16'h1234, 16'h5678, n, nb);
        checks++;
        if (nand_count !== 16'd96) begin
            failures++; $display("FAIL stat_count got=%0d want=96", nand_count);
        end
        for (int k = 0; k < 1030; k++) run_op(2'd3, 16'h0, 16'h0, n, nb);
        checks++;
        if (nand_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL stat_saturate got=%h want=ffff", nand_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_nand();
        test_xor();
        test_or_ignore();
        test_back_to_back();
        test_abort();
`ifdef NAND_STAT_EN
        test_stat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
